// File: rtl/cpu_trace_tx_if.sv
// CPU-side trace port: the CPU offers one record per result_ready and is
// released by a one-cycle next_out acknowledge.
interface cpu_trace_tx_if;
    logic       result_ready;
    logic [7:0] opcode;
    logic [7:0] pc_in;
    logic [7:0] operand_A;
    logic [7:0] operand_B;
    logic [7:0] result_in;
    logic       carry_in;
    logic       borrow_in;
    logic       next_out;

    modport master (
        output result_ready, opcode, pc_in, operand_A, operand_B,
               result_in, carry_in, borrow_in,
        input  next_out
    );

    modport slave (
        input  result_ready, opcode, pc_in, operand_A, operand_B,
               result_in, carry_in, borrow_in,
        output next_out
    );
endinterface

// File: rtl/cpu_trace_tx.sv
// CPU trace transmitter: captures executed-instruction records into a small
// FIFO (with a hold-off window against a sticky result_ready) and sends each
// record as six 8N1 bytes: pc, opcode, operand_A, operand_B, result, flags.
module cpu_trace_tx #(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int HOLDOFF      = 6
) (
    input  logic          clk,
    input  logic          rst,
    cpu_trace_tx_if.slave cpu,
    output logic          serial_out,
    output logic          tx_busy,
    output logic [3:0]    fifo_count,
    output logic [7:0]    records_sent
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HO_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [HO_W-1:0]  HO_LOAD    = HO_W'(HOLDOFF);
    localparam logic [3:0]       COUNT_FULL = 4'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Records are stored as {pc, opcode, A, B, result, flags}; the shifter
    // wants the first byte on the wire in bits [7:0] so that a plain right
    // shift streams every byte LSB first in the required byte order.
    function automatic logic [47:0] wire_order(input logic [47:0] rec);
        return {rec[7:0], rec[15:8], rec[23:16], rec[31:24], rec[39:32], rec[47:40]};
    endfunction

    logic [47:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [HO_W-1:0]  holdoff_r;
    logic             next_out_r;
    logic [47:0]      record_s;
    logic             capture_s;
    logic             pop_s;

    tx_state_t        state_r, state_s;
    logic [47:0]      shift_r, shift_s;
    logic [CNT_W-1:0] bit_cnt_r, bit_cnt_s;
    logic [2:0]       bit_idx_r, bit_idx_s;
    logic [2:0]       byte_idx_r, byte_idx_s;
    logic             sent_s;
    logic             line_s;

    assign cpu.next_out = next_out_r;

    // Capture decision: a record is taken only outside hold-off and with room in the FIFO.
    always_comb begin
        record_s = {cpu.pc_in, cpu.opcode, cpu.operand_A, cpu.operand_B,
                    cpu.result_in, 6'b000000, cpu.borrow_in, cpu.carry_in};
        if (cpu.result_ready && (holdoff_r == {HO_W{1'b0}}) && (fifo_count < COUNT_FULL)) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
    end

    // FIFO storage; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (capture_s && !rst) begin
            mem_r[wr_ptr_r] <= record_s;
        end
    end

    // FIFO pointers, occupancy, hold-off timer and capture acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_count <= 4'd0;
            holdoff_r  <= {HO_W{1'b0}};
            next_out_r <= 1'b0;
        end else begin
            if (capture_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({capture_s, pop_s})
                2'b10:   fifo_count <= fifo_count + 4'd1;
                2'b01:   fifo_count <= fifo_count - 4'd1;
                default: fifo_count <= fifo_count;
            endcase
            if (capture_s) begin
                holdoff_r <= HO_LOAD;
            end else if (holdoff_r != {HO_W{1'b0}}) begin
                holdoff_r <= holdoff_r - HO_W'(1);
            end
            next_out_r <= capture_s;
        end
    end

    // Serializer next-state logic; the line level is derived from the next state
    // so serial_out can be a plain register that is already correct in each state.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        bit_cnt_s  = bit_cnt_r;
        bit_idx_s  = bit_idx_r;
        byte_idx_s = byte_idx_r;
        pop_s      = 1'b0;
        sent_s     = 1'b0;
        line_s     = 1'b1;
        case (state_r)
            IDLE: begin
                if (fifo_count != 4'd0) begin
                    pop_s      = 1'b1;
                    shift_s    = wire_order(mem_r[rd_ptr_r]);
                    byte_idx_s = 3'd0;
                    bit_cnt_s  = {CNT_W{1'b0}};
                    state_s    = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bit_cnt_r == BIT_LAST) begin
                    bit_cnt_s = {CNT_W{1'b0}};
                    bit_idx_s = 3'd0;
                    state_s   = DATA;
                end else begin
                    bit_cnt_s = bit_cnt_r + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_cnt_r == BIT_LAST) begin
                    bit_cnt_s = {CNT_W{1'b0}};
                    shift_s   = {1'b0, shift_r[47:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    bit_cnt_s = bit_cnt_r + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_cnt_r == BIT_LAST) begin
                    bit_cnt_s = {CNT_W{1'b0}};
                    if (byte_idx_r == 3'd5) begin
                        sent_s  = 1'b1;
                        state_s = IDLE;
                    end else begin
                        byte_idx_s = byte_idx_r + 3'd1;
                        state_s    = START;
                    end
                end else begin
                    bit_cnt_s = bit_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        case (state_s)
            START:   line_s = 1'b0;
            DATA:    line_s = shift_s[0];
            default: line_s = 1'b1;
        endcase
    end

    // Serializer state and registered line/busy/record-count outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            shift_r      <= 48'd0;
            bit_cnt_r    <= {CNT_W{1'b0}};
            bit_idx_r    <= 3'd0;
            byte_idx_r   <= 3'd0;
            serial_out   <= 1'b1;
            tx_busy      <= 1'b0;
            records_sent <= 8'd0;
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            bit_cnt_r  <= bit_cnt_s;
            bit_idx_r  <= bit_idx_s;
            byte_idx_r <= byte_idx_s;
            serial_out <= line_s;
            tx_busy    <= (state_s != IDLE);
            if (sent_s) begin
                records_sent <= records_sent + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_tx.sv
// Testbench for cpu_trace_tx: a record-level reference model (FIFO queue,
// hold-off countdown, serializer busy timer) is stepped alongside the DUT and
// compared every cycle; each transmitted frame is compared sample-by-sample
// against the ideal 8N1 waveform of the record the model says was popped.
module tb_cpu_trace_tx;

    localparam int DEPTH   = 4;
    localparam int CPB     = 4;
    localparam int HOLDOFF = 6;
    localparam int REC_CYC = 60 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_out;
    logic       tx_busy;
    logic [3:0] fifo_count;
    logic [7:0] records_sent;

    cpu_trace_tx_if bus ();

    cpu_trace_tx #(
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB),
        .HOLDOFF      (HOLDOFF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu          (bus),
        .serial_out   (serial_out),
        .tx_busy      (tx_busy),
        .fifo_count   (fifo_count),
        .records_sent (records_sent)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [47:0] m_q[$];
    logic [47:0] m_txq[$];
    int          m_ho    = 0;
    int          m_timer = 0;
    int          m_total = 0;
    logic [7:0]  m_sent  = 8'd0;
    bit          m_next  = 1'b0;

    // Frame monitor state
    bit          mon_active = 1'b0;
    int          mon_idx    = 0;
    bit          mon_buf [REC_CYC];
    logic [47:0] last_bytes = 48'd0;

    localparam logic [47:0] R0 = 48'h03_81_05_07_0C_00;

    typedef struct {
        bit rr;
        bit rs;
        int ncyc;
        int pulses;
        int count;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input bit ok, input string detail);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Ideal line level k cycles into a record frame.
    function automatic bit exp_level(input logic [47:0] rec, input int k);
        int         byte_i;
        int         pos;
        logic [7:0] b;
        byte_i = k / (10 * CPB);
        pos    = (k % (10 * CPB)) / CPB;
        b      = rec[47 - 8 * byte_i -: 8];
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos - 1];
    endfunction

    task automatic frame_check();
        logic [47:0] exp;
        int          errs;
        errs = 0;
        for (int j = 0; j < 6; j++) begin
            for (int b = 0; b < 8; b++) begin
                last_bytes[40 - 8 * j + b] = mon_buf[j * 10 * CPB + (b + 1) * CPB + CPB / 2];
            end
        end
        if (m_txq.size() == 0) begin
            check("frame_unexpected", 1'b0, $sformatf("got frame %h, want none", last_bytes));
        end else begin
            exp = m_txq.pop_front();
            for (int k = 0; k < REC_CYC; k++) begin
                if (mon_buf[k] != exp_level(exp, k)) errs++;
            end
            check("frame", errs == 0,
                  $sformatf("decoded %h with %0d bad samples, want %h exact", last_bytes, errs, exp));
        end
    endtask

    // One clock cycle: drive inputs, advance the model, then compare at negedge.
    task automatic step(input bit rr, input bit rs, input logic [47:0] rec);
        bit          cap;
        bit          pop;
        bit          exp_busy;
        logic [47:0] norm;
        rst              = rs;
        bus.result_ready = rr;
        bus.pc_in        = rec[47:40];
        bus.opcode       = rec[39:32];
        bus.operand_A    = rec[31:24];
        bus.operand_B    = rec[23:16];
        bus.result_in    = rec[15:8];
        bus.borrow_in    = rec[1];
        bus.carry_in     = rec[0];
        norm             = {rec[47:8], 6'b000000, rec[1], rec[0]};
        if (rs) begin
            m_q.delete();
            m_txq.delete();
            m_ho    = 0;
            m_timer = 0;
            m_sent  = 8'd0;
            m_total = 0;
            m_next  = 1'b0;
        end else begin
            cap = rr && (m_ho == 0) && (m_q.size() < DEPTH);
            pop = (m_timer == 0) && (m_q.size() > 0);
            if (pop) begin
                m_txq.push_back(m_q.pop_front());
                m_timer = REC_CYC;
            end else if (m_timer > 0) begin
                m_timer--;
                if (m_timer == 0) begin
                    m_sent = m_sent + 8'd1;
                    m_total++;
                end
            end
            if (cap) m_q.push_back(norm);
            if (cap) m_ho = HOLDOFF;
            else if (m_ho > 0) m_ho--;
            m_next = cap;
        end
        @(posedge clk);
        @(negedge clk);
        exp_busy = (m_timer > 0);
        check("cycle",
              (bus.next_out === m_next) && (fifo_count === 4'(m_q.size())) &&
              (tx_busy === exp_busy) && (records_sent === m_sent) &&
              (exp_busy || (serial_out === 1'b1)),
              $sformatf("t=%0t next_out %b want %b, fifo_count %0d want %0d, tx_busy %b want %b, records_sent %0d want %0d, serial_out %b",
                        $time, bus.next_out, m_next, fifo_count, m_q.size(), tx_busy, exp_busy,
                        records_sent, m_sent, serial_out));
        if (rs) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && (serial_out == 1'b0)) begin
                mon_active = 1'b1;
                mon_idx    = 0;
            end
            if (mon_active) begin
                mon_buf[mon_idx] = serial_out;
                mon_idx++;
                if (mon_idx == REC_CYC) begin
                    mon_active = 1'b0;
                    frame_check();
                end
            end
        end
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            step(1'b0, 1'b0, R0);
            if (tx_busy == 1'b0) done = 1'b1;
        end
        check(name, done, $sformatf("tx_busy still %b after 400 cycles, want 0", tx_busy));
    endtask

    function automatic logic [47:0] rand_rec();
        logic [47:0] r;
        r[47:16] = $urandom();
        r[15:0]  = 16'($urandom());
        return r;
    endfunction

    int  pulses;
    bit  done;

    initial begin
        rst = 1'b1;
        // rr, rst, cycles, next_out pulses, fifo_count at end
        tbl[0] = '{1'b0, 1'b1,   2, 0, 0};  // reset state
        tbl[1] = '{1'b1, 1'b0,   1, 1, 1};  // first capture, serializer pops next cycle
        tbl[2] = '{1'b0, 1'b0,   7, 0, 0};  // hold-off expires while serializer busy
        tbl[3] = '{1'b1, 1'b0,  20, 3, 3};  // sticky result_ready: captures at 0, 7, 14
        tbl[4] = '{1'b1, 1'b0,  10, 1, 4};  // fourth capture fills FIFO, later attempt withheld
        tbl[5] = '{1'b1, 1'b0, 206, 1, 4};  // withheld until first pop, then captured
        tbl[6] = '{1'b0, 1'b0, 330, 0, 3};  // next record popped, now mid byte 2
        tbl[7] = '{1'b0, 1'b1,   1, 0, 0};  // reset aborts transmission and empties FIFO

        for (int e = 0; e < 8; e++) begin
            pulses = 0;
            for (int i = 0; i < tbl[e].ncyc; i++) begin
                step(tbl[e].rr, tbl[e].rs, R0);
                if (bus.next_out) pulses++;
            end
            check($sformatf("table%0d_pulses", e), pulses == tbl[e].pulses,
                  $sformatf("got %0d, want %0d", pulses, tbl[e].pulses));
            check($sformatf("table%0d_count", e), fifo_count == 4'(tbl[e].count),
                  $sformatf("got %0d, want %0d", fifo_count, tbl[e].count));
        end
        check("abort_line", (serial_out == 1'b1) && (tx_busy == 1'b0),
              $sformatf("serial_out %b tx_busy %b, want 1 0", serial_out, tx_busy));

        // Single known record
        step(1'b1, 1'b0, R0);
        check("single_ack", bus.next_out == 1'b1, $sformatf("next_out %b, want 1", bus.next_out));
        wait_idle("single_timeout");
        check("single_sent", records_sent == 8'd1, $sformatf("got %0d, want 1", records_sent));
        check("single_bytes", last_bytes == 48'h03_81_05_07_0C_00,
              $sformatf("got %h, want 038105070c00", last_bytes));

        // Flags byte with carry and borrow set
        step(1'b1, 1'b0, 48'h11_22_33_44_55_03);
        wait_idle("flags_timeout");
        check("flags_byte", last_bytes[7:0] == 8'h03, $sformatf("got %h, want 03", last_bytes[7:0]));
        check("flags_sent", records_sent == 8'd2, $sformatf("got %0d, want 2", records_sent));

        // Capture in the same cycle as a pop with two records queued
        step(1'b0, 1'b1, R0);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, rand_rec());
        check("sim_pre_count", fifo_count == 4'd2, $sformatf("got %0d, want 2", fifo_count));
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (m_timer == 0) done = 1'b1;
            else step(1'b0, 1'b0, R0);
        end
        check("sim_timeout", done, "serializer never went idle within 300 cycles");
        step(1'b1, 1'b0, rand_rec());
        check("sim_count", (fifo_count == 4'd2) && (bus.next_out == 1'b1) && (tx_busy == 1'b1),
              $sformatf("fifo_count %0d next_out %b tx_busy %b, want 2 1 1",
                        fifo_count, bus.next_out, tx_busy));

        // Random traffic with occasional resets
        step(1'b0, 1'b1, R0);
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 399) == 0), rand_rec());
        end

        // records_sent wraps after 256 records
        step(1'b0, 1'b1, R0);
        for (int i = 0; i < 70000 && m_total < 256; i++) begin
            step(($urandom_range(0, 3) != 0), 1'b0, rand_rec());
        end
        check("wrap_timeout", m_total == 256, $sformatf("only %0d records sent, want 256", m_total));
        check("wrap_value", records_sent == 8'd0, $sformatf("got %0d, want 0", records_sent));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_trace_tx.md
CPU_TRACE_TX -- requirements
Module: cpu_trace_tx

Interface
REQ-001 Parameter DEPTH, default 4, trace FIFO depth in records (power of two, 2..8).
REQ-002 Parameter CLKS_PER_BIT, default 4, clk cycles per serial bit (>=2).
REQ-003 Parameter HOLDOFF, default 6, cycles result_ready is ignored after a capture.
REQ-004 clk  in  1  sole clock; all state changes on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 result_ready  in  1  CPU record-valid; may stay high after consumption.
REQ-007 opcode  in  8  executed instruction byte.
REQ-008 pc_in  in  8  program counter of the record.
REQ-009 operand_A  in  8  ALU operand A.
REQ-010 operand_B  in  8  ALU operand B.
REQ-011 result_in  in  8  ALU result.
REQ-012 carry_in  in  1  ALU carry.
REQ-013 borrow_in  in  1  ALU borrow.
REQ-014 next_out  out  1  one-cycle pulse acknowledging a capture; releases the CPU.
REQ-015 serial_out  out  1  8N1 serial stream, idle high.
REQ-016 tx_busy  out  1  high while the serializer is outside IDLE.
REQ-017 fifo_count  out  4  records held in FIFO, 0..DEPTH.
REQ-018 records_sent  out  8  count of fully transmitted records, wraps 255->0.

Function
REQ-019 Capture condition in cycle N: result_ready=1, holdoff counter=0, fifo_count<DEPTH; the {pc_in, opcode, operand_A, operand_B, result_in, {6'b0, borrow_in, carry_in}} record is written at the end of cycle N.
REQ-020 next_out SHALL be 1 exactly in cycle N+1 after each capture, 0 otherwise.
REQ-021 On capture, holdoff counter loads HOLDOFF and decrements each cycle to 0; result_ready is ignored while it is nonzero.
REQ-022 FIFO full (fifo_count=DEPTH): no capture, next_out stays 0, CPU stalls; no record is dropped or overwritten.
REQ-023 Simultaneous capture and pop in one cycle: fifo_count unchanged, both take effect.
REQ-024 FIFO read/write pointers wrap modulo DEPTH.
REQ-025 Serializer FSM states: IDLE, START, DATA, STOP.
REQ-026 IDLE with fifo_count>0: pop the oldest record into a 48-bit shift register, set byte index 0, go to START next cycle.
REQ-027 START: serial_out=0 for CLKS_PER_BIT cycles, then DATA.
REQ-028 DATA: 8 bits of the current byte, LSB first, each held CLKS_PER_BIT cycles, then STOP.
REQ-029 STOP: serial_out=1 for CLKS_PER_BIT cycles; byte index<5 -> increment, START; byte index=5 -> records_sent+1, IDLE.
REQ-030 Byte order per record: pc, opcode, operand_A, operand_B, result, flags.
REQ-031 A record occupies exactly 60*CLKS_PER_BIT cycles (240 at default) from the first START cycle to the last STOP cycle; back-to-back records have exactly 1 IDLE cycle between them.
REQ-032 serial_out=1 in IDLE.

Reset
REQ-033 With rst=1 at a posedge: FIFO emptied, fifo_count=0, holdoff=0, FSM=IDLE, serial_out=1, tx_busy=0, next_out=0, records_sent=0.
REQ-034 Reset mid-record aborts transmission immediately (serial_out=1 the next cycle); buffered records are discarded.
REQ-035 rst has priority over capture and pop in the same cycle.

Verification
REQ-036 Single record: pc=0x03, opcode=0x81, A=5, B=7, result=12, carry=0, borrow=0 -> next_out pulse one cycle after capture; serial bytes 03,81,05,07,0C,00; records_sent=1.
REQ-037 Sticky result_ready held high for 20 cycles with HOLDOFF=6 -> captures on cycles 0, 7, 14 only; fifo_count=3.
REQ-038 Fill: 5 captures attempted while serializer busy (DEPTH=4) -> 4th capture sets fifo_count=4; 5th withheld, next_out=0 until the first pop, then captured.
REQ-039 Flags byte: carry=1, borrow=1 -> 6th byte 0x03; bit times measured at exactly CLKS_PER_BIT cycles.
REQ-040 Reset asserted during byte 2 of a record with 2 records queued -> serial_out=1, fifo_count=0, tx_busy=0 next cycle; no further bytes sent.
REQ-041 Simultaneous pop and capture with fifo_count=2 -> fifo_count stays 2; records_sent wraps 255->0 after 256 records.
